// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG operand TAP: TAP states, IR codes and
// default identification code.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_TLR,
    TAP_RTI,
    TAP_SEL_DR,
    TAP_CAP_DR,
    TAP_SHIFT_DR,
    TAP_EX1_DR,
    TAP_PAUSE_DR,
    TAP_EX2_DR,
    TAP_UPD_DR,
    TAP_SEL_IR,
    TAP_CAP_IR,
    TAP_SHIFT_IR,
    TAP_EX1_IR,
    TAP_PAUSE_IR,
    TAP_EX2_IR,
    TAP_UPD_IR
  } tap_state_t;

  localparam logic [1:0] IR_RESULT  = 2'b00;
  localparam logic [1:0] IR_IDCODE  = 2'b01;
  localparam logic [1:0] IR_OPERAND = 2'b10;
  localparam logic [1:0] IR_BYPASS  = 2'b11;

  localparam logic [31:0] DEFAULT_IDCODE = 32'h1000_0001;

  // Length of the data register selected by an instruction.
  function automatic logic [5:0] dr_len(input logic [1:0] ir);
    case (ir)
      IR_IDCODE:  dr_len = 6'd32;
      IR_OPERAND: dr_len = 6'd16;
      IR_RESULT:  dr_len = 6'd8;
      default:    dr_len = 6'd1;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller; advances one state per synchronized tck rise.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tck_rise,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t state_next;

  // State register, stepped only on a tck rising-edge strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= TAP_TLR;
    else if (tck_rise) state <= state_next;
  end

  // Standard TMS-driven transitions.
  always_comb begin
    state_next = state;
    case (state)
      TAP_TLR:      state_next = tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:      state_next = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR:   state_next = tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR:   state_next = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR: state_next = tms ? TAP_EX1_DR : TAP_SHIFT_DR;
      TAP_EX1_DR:   state_next = tms ? TAP_UPD_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR: state_next = tms ? TAP_EX2_DR : TAP_PAUSE_DR;
      TAP_EX2_DR:   state_next = tms ? TAP_UPD_DR : TAP_SHIFT_DR;
      TAP_UPD_DR:   state_next = tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR:   state_next = tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR:   state_next = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR: state_next = tms ? TAP_EX1_IR : TAP_SHIFT_IR;
      TAP_EX1_IR:   state_next = tms ? TAP_UPD_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR: state_next = tms ? TAP_EX2_IR : TAP_PAUSE_IR;
      TAP_EX2_IR:   state_next = tms ? TAP_UPD_IR : TAP_SHIFT_IR;
      TAP_UPD_IR:   state_next = tms ? TAP_SEL_DR : TAP_RTI;
      default:      state_next = TAP_TLR;
    endcase
  end

endmodule

// File: rtl/jtag_operand_tap.sv
// JTAG TAP, oversampled on clk, that loads two 8-bit operands for a
// downstream AND stage and reads its 8-bit result back.
module jtag_operand_tap
  import jtag_pkg::*;
#(
  parameter logic [31:0] IDCODE      = DEFAULT_IDCODE,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic       tdo_oe,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic       op_valid,
  input  logic [7:0] res_y
);

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic                   tck_prev;
  logic                   tck_s, tms_s, tdi_s;
  logic                   tck_rise, tck_fall;
  tap_state_t             state;
  logic [1:0]             ir;
  logic [31:0]            sr;
  logic [31:0]            capture_val;
  logic                   shifting;

  // Shift in tdi at the top of the selected register length; bits above
  // the length are don't-care and never observed.
  function automatic logic [31:0] shift_in(input logic [31:0] cur,
                                           input logic bit_in,
                                           input logic [5:0] len);
    logic [31:0] nxt;
    nxt = cur >> 1;
    nxt[5'(len - 6'd1)] = bit_in;
    return nxt;
  endfunction

  // Synchronizer chains for the three JTAG pins plus previous tck for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_prev <= 1'b0;
    end else begin
      tck_sync[0] <= tck;
      tms_sync[0] <= tms;
      tdi_sync[0] <= tdi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        tck_sync[i] <= tck_sync[i-1];
        tms_sync[i] <= tms_sync[i-1];
        tdi_sync[i] <= tdi_sync[i-1];
      end
      tck_prev <= tck_sync[SYNC_STAGES-1];
    end
  end

  assign tck_s    = tck_sync[SYNC_STAGES-1];
  assign tms_s    = tms_sync[SYNC_STAGES-1];
  assign tdi_s    = tdi_sync[SYNC_STAGES-1];
  assign tck_rise = tck_s & ~tck_prev;
  assign tck_fall = ~tck_s & tck_prev;
  assign shifting = (state == TAP_SHIFT_DR) || (state == TAP_SHIFT_IR);

  jtag_tap_fsm u_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .tck_rise (tck_rise),
    .tms      (tms_s),
    .state    (state)
  );

  // Value loaded into the shift register in Capture-DR for the current IR.
  always_comb begin
    capture_val = '0;
    case (ir)
      IR_IDCODE:  capture_val = {IDCODE[31:1], 1'b1};
      IR_OPERAND: capture_val = {16'h0000, op_b, op_a};
      IR_RESULT:  capture_val = {24'h000000, res_y};
      default:    capture_val = '0;
    endcase
  end

  // Capture/shift on tck rise; tdo, IR update and operand update on tck fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      ir       <= IR_IDCODE;
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
      tdo      <= 1'b0;
      tdo_oe   <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      if (state == TAP_TLR) ir <= IR_IDCODE;
      if (tck_rise) begin
        case (state)
          TAP_CAP_IR:   sr <= 32'h0000_0001;
          TAP_SHIFT_IR: sr <= shift_in(sr, tdi_s, 6'd2);
          TAP_CAP_DR:   sr <= capture_val;
          TAP_SHIFT_DR: sr <= shift_in(sr, tdi_s, dr_len(ir));
          default: ;
        endcase
      end
      if (tck_fall) begin
        tdo_oe <= shifting;
        tdo    <= shifting & sr[0];
        case (state)
          TAP_UPD_IR: ir <= sr[1:0];
          TAP_UPD_DR: begin
            if (ir == IR_OPERAND) begin
              op_a     <= sr[7:0];
              op_b     <= sr[15:8];
              op_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/jtag_operand_tap.md
JTAG_OPERAND_TAP -- requirements
Module: jtag_operand_tap

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1000_0001, 32-bit device ID with bit 0 fixed to 1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on tck, tms and tdi.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tck  input  1  JTAG test clock, asynchronous to clk.
REQ-006 SHALL have port tms  input  1  JTAG mode select.
REQ-007 SHALL have port tdi  input  1  JTAG serial data in.
REQ-008 SHALL have port tdo  output  1  JTAG serial data out.
REQ-009 SHALL have port tdo_oe  output  1  tdo drive enable.
REQ-010 SHALL have port op_a  output  8  operand A to the downstream AND stage.
REQ-011 SHALL have port op_b  output  8  operand B to the downstream AND stage.
REQ-012 SHALL have port op_valid  output  1  one-clk pulse when new operands are applied.
REQ-013 SHALL have port res_y  input  8  result returned by the downstream AND stage.

Function
REQ-014 SHALL pass tck, tms and tdi through SYNC_STAGES flops each; tck_rise/tck_fall are single-clk strobes from synchronized tck vs its previous value.
REQ-015 SHALL sample tms and tdi, and advance TAP state, only on tck_rise; tdo and tdo_oe change only on tck_fall.
REQ-016 SHALL implement the 16-state IEEE 1149.1 TAP FSM with standard TMS transitions; five consecutive tck_rise with tms=1 reach Test-Logic-Reset from any state.
REQ-017 SHALL use a 2-bit IR: 00 RESULT, 01 IDCODE, 10 OPERAND, 11 BYPASS; Test-Logic-Reset forces IR=01.
REQ-018 SHALL load 2'b01 in Capture-IR, shift LSB first in Shift-IR, and transfer the shift register to IR in Update-IR.
REQ-019 SHALL select DR by IR: IDCODE 32-bit, OPERAND 16-bit, RESULT 8-bit, BYPASS 1-bit (captures 0).
REQ-020 SHALL capture in Capture-DR: IDCODE, current {op_b,op_a}, res_y, or 0 respectively; shift LSB first with tdi entering MSB.
REQ-021 SHALL, in Update-DR with IR=OPERAND, load op_a=sr[7:0] and op_b=sr[15:8] and pulse op_valid high for exactly one clk; other instructions leave operands unchanged.
REQ-022 SHALL drive tdo = shift register bit 0 and tdo_oe=1 in Shift-IR/Shift-DR; otherwise tdo=0 and tdo_oe=0.
REQ-023 SHALL treat simultaneous tck_rise and tck_fall as impossible (filtered); a tck high/low period shorter than 2 clk is unsupported.
REQ-024 SHALL give worst-case latency from a tck pin edge to the state/output update of SYNC_STAGES+1 clk.

Reset
REQ-025 SHALL, on rst_n low, asynchronously set TAP state=Test-Logic-Reset, IR=01, shift register=0, synchronizers=0, op_a=0, op_b=0, op_valid=0, tdo=0, tdo_oe=0.
REQ-026 SHALL abort any in-progress shift on reset mid-operation, with no op_valid pulse produced; operation resumes from Test-Logic-Reset after rst_n rises.

Structure
REQ-027 SHALL place the TAP state typedef, IR code constants and the default IDCODE in shared package jtag_pkg.
REQ-028 SHALL implement the TAP state machine as sub-module jtag_tap_fsm (inputs clk, rst_n, tck_rise, tms; output state).

Verification
REQ-029 SHALL cover: after reset, Shift-DR of 32 bits -> tdo returns 32'h1000_0001 LSB first, tdo_oe=1 only while shifting.
REQ-030 SHALL cover: IR=10, shift 16'hA55A, Update-DR -> op_a=8'h5A, op_b=8'hA5, op_valid high exactly one clk.
REQ-031 SHALL cover: IR=00 with res_y=8'h3C -> shifted-out 8 bits equal 8'h3C.
REQ-032 SHALL cover: IR=11, shift 8'hF0 through DR -> tdo returns 0 then tdi delayed one tck.
REQ-033 SHALL cover: from Shift-DR, tms=1 for 5 tck -> Test-Logic-Reset, IR=01, op_a/op_b unchanged.
REQ-034 SHALL cover: rst_n asserted mid Shift-DR of OPERAND -> all outputs 0 immediately, no op_valid pulse.
